// File: rtl/sisc_pkg.sv
// Shared SISC datapath definitions: default bus widths and memory responder state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sisc_pkg;

  localparam int SISC_DATA_W = 32;
  localparam int SISC_ADDR_W = 16;

  // Wait counter width; covers WAIT_CYCLES 0..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Index width for a word array of the given depth (at least one bit).
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with write enable and registered read data; no reset on contents.
// Latency: one edge from enable to q; writes return the written word (write-first).
// Backpressure: none; q holds its value whenever en is low.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled edge; q only moves when the array is accessed.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        q         <= wdata;
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: latches one read/write, waits WAIT_CYCLES, then pulses ready with rdata/err.
// Latency: ready rises WAIT_CYCLES+1 edges after the accept edge; lasts one cycle.
// Backpressure: req must stay high until ready; dropping req while waiting aborts with no side effects.
module dmem_resp
  import sisc_pkg::*;
#(
  parameter int DATA_W      = SISC_DATA_W,
  parameter int ADDR_W      = SISC_ADDR_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int AW = addr_bits(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rd_vld;
  logic [31:0]       addr_ext;
  logic              in_range;
  logic              fire;
  logic [DATA_W-1:0] arr_q;

  // Full-width compare against DEPTH so high address bits never alias into the array.
  assign addr_ext = 32'(lat_addr);
  assign in_range = (addr_ext < 32'(DEPTH));

  // The WAIT state always spans WAIT_CYCLES+1 cycles (one cycle even when WAIT_CYCLES is 0),
  // so the array is always driven from latched values on the edge that enters RESP.
  assign fire = (state == ST_WAIT) && req && (cnt == '0);

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk    (clk),
    .en     (fire && in_range),
    .we     (lat_we),
    .addr   (lat_addr[AW-1:0]),
    .wdata  (lat_wdata),
    .q      (arr_q)
  );

  // rd_vld masks the uninitialised/unreset array output and forces zero on out-of-range responses.
  assign rdata = rd_vld ? arr_q : '0;

  // Request FSM with wait counter, request latches and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_vld    <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            state     <= ST_WAIT;
            busy      <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (!req) begin
            // Abort: nothing written, rdata left as it was.
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state  <= ST_RESP;
            ready  <= 1'b1;
            err    <= !in_range;
            rd_vld <= in_range;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  logic        clk;
  logic        rst_f;

  // DUT with two wait states
  logic        req, we;
  logic [15:0] addr;
  logic [31:0] wdata, rdata;
  logic        ready, err, busy;

  // DUT with zero wait states
  logic        req0, we0;
  logic [15:0] addr0;
  logic [31:0] wdata0, rdata0;
  logic        ready0, err0, busy0;

  int checks = 0;
  int errors = 0;

  dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .clk   (clk),
    .rst_f (rst_f),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .busy  (busy)
  );

  dmem_resp #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_f (rst_f),
    .req   (req0),
    .we    (we0),
    .addr  (addr0),
    .wdata (wdata0),
    .rdata (rdata0),
    .ready (ready0),
    .err   (err0),
    .busy  (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the WAIT_CYCLES=2 DUT; inputs are scrambled after accept.
  task automatic run_txn(input logic t_we, input logic [15:0] t_addr, input logic [31:0] t_wdata,
                         input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                         input string tag);
    int  n;
    logic seen;
    req   = 1'b1;
    we    = t_we;
    addr  = t_addr;
    wdata = t_wdata;
    tick();  // accept edge
    we    = ~t_we;
    addr  = ~t_addr;
    wdata = ~t_wdata;
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
    check({tag, " ready_after_accept"}, 32'(ready), 32'd0);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = ready;
      if (!seen) check({tag, " busy_waiting"}, 32'(busy), 32'd1);
    end
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " busy_at_ready"}, 32'(busy), 32'd1);
    if (chk_rd) check({tag, " rdata"}, rdata, exp_rd);
    req = 1'b0;
    we  = 1'b0;
    tick();
    check({tag, " ready_pulse_end"}, 32'(ready), 32'd0);
    check({tag, " err_end"}, 32'(err), 32'd0);
    check({tag, " busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic seen;

    rst_f = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;

    // Reset state
    repeat (2) tick();
    check("rst ready", 32'(ready), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst rdata", rdata, 32'd0);
    #3 rst_f = 1'b1;
    tick();

    // Write then read back, rdata holds while idle
    run_txn(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, "wr10");
    run_txn(1'b0, 16'h0010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "rd10");
    repeat (5) tick();
    check("rd10 hold", rdata, 32'hDEADBEEF);

    // Out of range: error, zero data, no alias into word 0
    run_txn(1'b1, 16'h0000, 32'hA5A50000, 1'b0, 1'b0, 32'h0, "wr00");
    run_txn(1'b1, 16'h0100, 32'h12345678, 1'b1, 1'b1, 32'h0, "oor");
    run_txn(1'b0, 16'h0000, 32'h0, 1'b0, 1'b1, 32'hA5A50000, "rd00");
    run_txn(1'b0, 16'hFF00, 32'h0, 1'b1, 1'b1, 32'h0, "oor_rd");

    // Abort after one wait cycle
    run_txn(1'b1, 16'h0020, 32'h00000011, 1'b0, 1'b0, 32'h0, "wr20");
    run_txn(1'b0, 16'h0010, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, "rd10b");
    req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 32'h5;
    tick();  // accept
    tick();  // first wait edge
    check("abort busy_mid", 32'(busy), 32'd1);
    req = 1'b0;
    tick();  // abort edge
    check("abort busy", 32'(busy), 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (ready) seen = 1'b1;
    end
    check("abort no_ready", 32'(seen), 32'd0);
    check("abort rdata_kept", rdata, 32'hDEADBEEF);
    run_txn(1'b0, 16'h0020, 32'h0, 1'b0, 1'b1, 32'h00000011, "rd20");

    // Back-to-back: write 3=7 then read 3 with req held high
    req = 1'b1; we = 1'b1; addr = 16'h0003; wdata = 32'h7;
    tick();  // accept
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++; seen = ready;
    end
    check("b2b first_latency", 32'(n), 32'd3);
    we = 1'b0; wdata = 32'h0;
    // RESP->IDLE edge, accept edge, then WAIT_CYCLES+1 edges: 1 + 1 + 3
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      tick(); n++; seen = ready;
      if (n == 1) check("b2b idle_busy", 32'(busy), 32'd0);
    end
    check("b2b gap", 32'(n), 32'd5);
    check("b2b rdata", rdata, 32'h7);
    check("b2b err", 32'(err), 32'd0);
    req = 1'b0;
    tick();
    check("b2b busy_end", 32'(busy), 32'd0);

    // Async reset in the middle of a pending write
    run_txn(1'b1, 16'h0040, 32'h00000077, 1'b0, 1'b0, 32'h0, "wr40");
    req = 1'b1; we = 1'b1; addr = 16'h0040; wdata = 32'h99;
    tick();  // accept
    tick();  // waiting
    #2 rst_f = 1'b0;
    #1;
    check("arst busy", 32'(busy), 32'd0);
    check("arst ready", 32'(ready), 32'd0);
    check("arst err", 32'(err), 32'd0);
    check("arst rdata", rdata, 32'd0);
    req = 1'b0; we = 1'b0;
    #3 rst_f = 1'b1;
    tick();
    run_txn(1'b0, 16'h0040, 32'h0, 1'b0, 1'b1, 32'h00000077, "rd40");

    // Zero wait states: ready on the first edge after accept
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 32'h0000CAFE;
    tick();  // accept
    check("w0 wr ready_at_accept", 32'(ready0), 32'd0);
    check("w0 wr busy", 32'(busy0), 32'd1);
    tick();
    check("w0 wr ready", 32'(ready0), 32'd1);
    check("w0 wr err", 32'(err0), 32'd0);
    req0 = 1'b0; we0 = 1'b0;
    tick();
    check("w0 wr ready_end", 32'(ready0), 32'd0);
    req0 = 1'b1; addr0 = 16'h0005;
    tick();  // accept
    addr0 = 16'h0006;
    tick();
    check("w0 rd ready", 32'(ready0), 32'd1);
    check("w0 rd rdata", rdata0, 32'h0000CAFE);
    req0 = 1'b0;
    tick();
    check("w0 rd busy_end", 32'(busy0), 32'd0);
    check("w0 rd rdata_hold", rdata0, 32'h0000CAFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
